// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future receiver.
// Contents: parity encodings, transmitter state enum, baud divisor and
// ceil-log2 helpers usable in constant expressions.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   // Clock cycles per bit, rounded to nearest.
   function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   // Ceil(log2(v)); returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (flushes pointers)
//   i_push, i_data   write request/data; ignored while full
//   i_pop            read request; ignored while empty
//   o_data_c         head entry (combinational read of the array)
//   o_full, o_empty  registered status
//   o_level          registered entry count, 0..DEPTH
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_pop,
   output logic [WIDTH-1:0]        o_data_c,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW    = clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_full;
   logic             r_empty;

   logic             w_push;
   logic             w_pop;
   logic [LVL_W-1:0] w_level_next;

   // Gate requests with the registered status flags.
   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & ~r_empty;

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      w_level_next = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_next = r_level + LVL_W'(1);
         2'b01:   w_level_next = r_level - LVL_W'(1);
         default: w_level_next = r_level;
      endcase
   end

   // Pointers and status.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= w_level_next;
         r_full  <= (w_level_next == LVL_FULL);
         r_empty <= (w_level_next == '0);
      end
   end

   // Storage array needs no reset; pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data_c = r_mem[r_rd_ptr];
   assign o_full   = r_full;
   assign o_empty  = r_empty;
   assign o_level  = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO write port feeding a frame serialiser
// with configurable data width, parity and stop bits.
// Ports:
//   clock, resetN       clock, async active-low reset
//   writeEnable/Data    push a word into the FIFO (dropped while full)
//   sendBreak           only with UART_TX_FIFO_BREAK_EN: hold line low
//                       between frames
//   full, empty, level  FIFO status
//   overflow            sticky, set by a write while full
//   busy                frame (or break) on the line
//   tx                  serial output, idle high
// Optional feature macro: UART_TX_FIFO_BREAK_EN.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned BAUD_RATE       = 115200,
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned PARITY          = 0,
   parameter int unsigned STOP_BITS       = 1,
   parameter int unsigned FIFO_DEPTH      = 16
) (
   input  logic                        clock,
   input  logic                        resetN,
   input  logic                        writeEnable,
   input  logic [DATA_BITS-1:0]        writeData,
`ifdef UART_TX_FIFO_BREAK_EN
   input  logic                        sendBreak,
`endif
   output logic                        full,
   output logic                        empty,
   output logic [clog2(FIFO_DEPTH):0]  level,
   output logic                        overflow,
   output logic                        busy,
   output logic                        tx
);

   localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int unsigned CNT_W   = clog2(DIVISOR);
   localparam int unsigned BIT_W   = clog2(DATA_BITS) + 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   // FIFO interface
   logic [DATA_BITS-1:0]       w_fifo_data;
   logic                       w_full;
   logic                       w_empty;
   logic [clog2(FIFO_DEPTH):0] w_level;
   logic                       w_pop;
   logic                       w_break;
   logic                       w_par_load;

   // FSM registers and next values
   tx_state_t            r_state;
   tx_state_t            w_state_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_next;
   logic [BIT_W-1:0]     r_bit;
   logic [BIT_W-1:0]     w_bit_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic                 r_par;
   logic                 w_par_next;
   logic                 w_bit_end;
   logic                 w_line;
   logic                 w_active;

   // Output registers
   logic r_tx;
   logic r_busy;
   logic r_overflow;

`ifdef UART_TX_FIFO_BREAK_EN
   assign w_break = sendBreak;
`else
   assign w_break = 1'b0;
`endif

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk    (clock),
      .i_rst_n  (resetN),
      .i_push   (writeEnable),
      .i_data   (writeData),
      .i_pop    (w_pop),
      .o_data_c (w_fifo_data),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_level  (w_level)
   );

   // Parity bit that makes data+parity odd (ODD) or even (EVEN).
   assign w_par_load = (PARITY == PARITY_ODD) ? ~(^w_fifo_data) : (^w_fifo_data);

   assign w_bit_end = (r_cnt == CNT_LAST);

   // Next-state, counters, shifter and line level.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + CNT_W'(1);
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_par_next   = r_par;
      w_pop        = 1'b0;
      w_line       = 1'b1;
      w_active     = 1'b1;

      case (r_state)
         TX_IDLE: begin
            w_cnt_next = '0;
            w_bit_next = '0;
            w_line     = ~w_break;
            w_active   = w_break;
            if (!w_empty && !w_break) begin
               w_pop        = 1'b1;
               w_state_next = TX_START;
            end
         end
         TX_START: begin
            w_line = 1'b0;
            if (w_bit_end) begin
               w_cnt_next   = '0;
               w_bit_next   = '0;
               w_state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            w_line = r_shift[0];
            if (w_bit_end) begin
               w_cnt_next   = '0;
               w_shift_next = r_shift >> 1;
               if (r_bit == DATA_LAST) begin
                  w_bit_next   = '0;
                  w_state_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
               end else begin
                  w_bit_next = r_bit + BIT_W'(1);
               end
            end
         end
         TX_PARITY: begin
            w_line = r_par;
            if (w_bit_end) begin
               w_cnt_next   = '0;
               w_bit_next   = '0;
               w_state_next = TX_STOP;
            end
         end
         TX_STOP: begin
            w_line = 1'b1;
            if (w_bit_end) begin
               w_cnt_next = '0;
               if (r_bit == STOP_LAST) begin
                  w_bit_next = '0;
                  // Chain straight into the next start bit when work is queued.
                  if (!w_empty && !w_break) begin
                     w_pop        = 1'b1;
                     w_state_next = TX_START;
                  end else begin
                     w_state_next = TX_IDLE;
                  end
               end else begin
                  w_bit_next = r_bit + BIT_W'(1);
               end
            end
         end
         default: begin
            w_cnt_next   = '0;
            w_bit_next   = '0;
            w_state_next = TX_IDLE;
         end
      endcase

      // Popping loads the head word and its parity for the new frame.
      if (w_pop) begin
         w_shift_next = w_fifo_data;
         w_par_next   = w_par_load;
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= TX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_par   <= w_par_next;
      end
   end

   // Registered outputs; line level follows state by one cycle.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_tx   <= w_line;
         r_busy <= w_active;
         if (writeEnable && w_full) r_overflow <= 1'b1;
      end
   end

   assign tx       = r_tx;
   assign busy     = r_busy;
   assign overflow = r_overflow;
   assign full     = w_full;
   assign empty    = w_empty;
   assign level    = w_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances at DIVISOR=10
// (a: 8N1 depth 16, b: 7E2 depth 16, c: 8N1 depth 4).
module tb_uart_tx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, we_a, full_a, empty_a, ovf_a, busy_a, tx_a;
   logic [7:0] wd_a;
   logic [4:0] lvl_a;
   logic       rst_b, we_b, full_b, empty_b, ovf_b, busy_b, tx_b;
   logic [6:0] wd_b;
   logic [4:0] lvl_b;
   logic       rst_c, we_c, full_c, empty_c, ovf_c, busy_c, tx_c;
   logic [7:0] wd_c;
   logic [2:0] lvl_c;
`ifdef UART_TX_FIFO_BREAK_EN
   logic brk_a, brk_b, brk_c;
`endif

   uart_tx_fifo #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
      .clock(clk), .resetN(rst_a), .writeEnable(we_a), .writeData(wd_a),
`ifdef UART_TX_FIFO_BREAK_EN
      .sendBreak(brk_a),
`endif
      .full(full_a), .empty(empty_a), .level(lvl_a), .overflow(ovf_a),
      .busy(busy_a), .tx(tx_a));

   uart_tx_fifo #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
      .clock(clk), .resetN(rst_b), .writeEnable(we_b), .writeData(wd_b),
`ifdef UART_TX_FIFO_BREAK_EN
      .sendBreak(brk_b),
`endif
      .full(full_b), .empty(empty_b), .level(lvl_b), .overflow(ovf_b),
      .busy(busy_b), .tx(tx_b));

   uart_tx_fifo #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
      .clock(clk), .resetN(rst_c), .writeEnable(we_c), .writeData(wd_c),
`ifdef UART_TX_FIFO_BREAK_EN
      .sendBreak(brk_c),
`endif
      .full(full_c), .empty(empty_c), .level(lvl_c), .overflow(ovf_c),
      .busy(busy_c), .tx(tx_c));

   typedef struct {
      int          sel;
      logic [8:0]  data;
      logic [15:0] frame;   // bit i = i-th bit on the line, start bit first
      int          blen;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(input int sel);
      case (sel)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic empty_of(input int sel);
      case (sel)
         0:       return empty_a;
         1:       return empty_b;
         default: return empty_c;
      endcase
   endfunction

   task automatic write_word(input int sel, input logic [8:0] d);
      case (sel)
         0:       begin we_a = 1'b1; wd_a = d[7:0]; end
         1:       begin we_b = 1'b1; wd_b = d[6:0]; end
         default: begin we_c = 1'b1; wd_c = d[7:0]; end
      endcase
      tick(1);
      we_a = 1'b0;
      we_b = 1'b0;
      we_c = 1'b0;
   endtask

   // Wait for a start bit, sample each bit mid-cell, count busy cycles.
   task automatic capture(input int sel, output logic [15:0] bits, output int blen);
      int w;
      int k;
      bits = '0;
      blen = 0;
      w = 0;
      while (tx_of(sel) !== 1'b0 && w < 300) begin
         tick(1);
         w++;
      end
      chk("frame_start", {31'b0, tx_of(sel)}, 32'd0);
      if (tx_of(sel) === 1'b0) begin
         k = 0;
         while (busy_of(sel) === 1'b1 && k < 2000) begin
            if ((k % 10) == 5 && k < 160) bits[k/10] = tx_of(sel);
            k++;
            tick(1);
         end
         blen = k;
      end
   endtask

   initial begin
      logic [15:0] bits;
      int          blen;
      int          cnt;

      vecs[0] = '{0, 9'h0A5, 16'b0000_0011_0100_1010, 100};
      vecs[1] = '{0, 9'h000, 16'b0000_0010_0000_0000, 100};
      vecs[2] = '{0, 9'h0FF, 16'b0000_0011_1111_1110, 100};
      vecs[3] = '{0, 9'h03C, 16'b0000_0010_0111_1000, 100};
      vecs[4] = '{1, 9'h003, 16'b0000_0110_0000_0110, 110};
      vecs[5] = '{1, 9'h007, 16'b0000_0111_0000_1110, 110};
      vecs[6] = '{1, 9'h055, 16'b0000_0110_1010_1010, 110};

      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      we_a = 1'b0;  we_b = 1'b0;  we_c = 1'b0;
      wd_a = '0;    wd_b = '0;    wd_c = '0;
`ifdef UART_TX_FIFO_BREAK_EN
      brk_a = 1'b0; brk_b = 1'b0; brk_c = 1'b0;
`endif
      tick(2);

      // Reset values
      chk("rst_tx",    {31'b0, tx_a},    32'd1);
      chk("rst_busy",  {31'b0, busy_a},  32'd0);
      chk("rst_empty", {31'b0, empty_a}, 32'd1);
      chk("rst_full",  {31'b0, full_a},  32'd0);
      chk("rst_level", {27'b0, lvl_a},   32'd0);
      chk("rst_ovf",   {31'b0, ovf_a},   32'd0);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      tick(2);

      // First-write latency: accept at n, pop at n+1, line low from n+2.
      we_a = 1'b1; wd_a = 8'hA5;
      tick(1);
      we_a = 1'b0;
      chk("lat_empty_n",  {31'b0, empty_a}, 32'd0);
      chk("lat_level_n",  {27'b0, lvl_a},   32'd1);
      chk("lat_tx_n",     {31'b0, tx_a},    32'd1);
      tick(1);
      chk("lat_tx_n1",    {31'b0, tx_a},    32'd1);
      chk("lat_busy_n1",  {31'b0, busy_a},  32'd0);
      chk("lat_level_n1", {27'b0, lvl_a},   32'd0);
      tick(1);
      chk("lat_tx_n2",    {31'b0, tx_a},    32'd0);
      chk("lat_busy_n2",  {31'b0, busy_a},  32'd1);
      cnt = 0;
      while (tx_a === 1'b0 && cnt < 20) begin
         cnt++;
         tick(1);
      end
      chk("start_width", cnt, 32'd10);
      cnt = 0;
      while (busy_a === 1'b1 && cnt < 200) begin
         cnt++;
         tick(1);
      end
      chk("lat_busy_len", cnt, 32'd90);

      // Table of single frames on a (8N1) and b (7E2).
      for (int i = 0; i < NV; i++) begin
         write_word(vecs[i].sel, vecs[i].data);
         capture(vecs[i].sel, bits, blen);
         chk($sformatf("vec%0d_frame", i), {16'b0, bits}, {16'b0, vecs[i].frame});
         chk($sformatf("vec%0d_busy_len", i), blen, vecs[i].blen);
         chk($sformatf("vec%0d_empty", i), {31'b0, empty_of(vecs[i].sel)}, 32'd1);
      end

      // Back-to-back: three words queued behind a running frame.
      write_word(0, 9'h011);
      tick(9);
      we_a = 1'b1; wd_a = 8'h22;
      tick(1);
      wd_a = 8'h33;
      tick(1);
      wd_a = 8'h44;
      tick(1);
      we_a = 1'b0;
      chk("b2b_level3",  {27'b0, lvl_a},  32'd3);
      tick(88);
      chk("b2b_lvl_n100", {27'b0, lvl_a}, 32'd3);
      chk("b2b_stop_tx",  {31'b0, tx_a},  32'd1);
      tick(1);
      chk("b2b_level2",  {27'b0, lvl_a},  32'd2);
      chk("b2b_busy1",   {31'b0, busy_a}, 32'd1);
      tick(1);
      chk("b2b_no_gap",  {31'b0, tx_a},   32'd0);
      tick(99);
      chk("b2b_level1",  {27'b0, lvl_a},  32'd1);
      chk("b2b_busy2",   {31'b0, busy_a}, 32'd1);
      tick(100);
      chk("b2b_level0",  {27'b0, lvl_a},  32'd0);
      cnt = 0;
      while (busy_a === 1'b1 && cnt < 300) begin
         cnt++;
         tick(1);
      end
      chk("b2b_tail", cnt, 32'd101);

      // Depth-4 overflow: six consecutive writes, first is popped.
      we_c = 1'b1; wd_c = 8'h00;
      tick(1);
      chk("ovf_level_n",  {29'b0, lvl_c}, 32'd1);
      tick(1);
      chk("ovf_level_n1", {29'b0, lvl_c}, 32'd1);
      tick(3);
      chk("ovf_full_n4",  {31'b0, full_c}, 32'd1);
      chk("ovf_flag_n4",  {31'b0, ovf_c},  32'd0);
      tick(1);
      we_c = 1'b0;
      chk("ovf_full",  {31'b0, full_c}, 32'd1);
      chk("ovf_flag",  {31'b0, ovf_c},  32'd1);
      chk("ovf_level", {29'b0, lvl_c},  32'd4);

      // Reset 35 cycles into the frame (line low on data bit 2).
      tick(31);
      chk("mid_tx_low", {31'b0, tx_c}, 32'd0);
      #2;
      rst_c = 1'b0;
      #1;
      chk("mr_tx",    {31'b0, tx_c},    32'd1);
      chk("mr_empty", {31'b0, empty_c}, 32'd1);
      chk("mr_level", {29'b0, lvl_c},   32'd0);
      chk("mr_busy",  {31'b0, busy_c},  32'd0);
      chk("mr_full",  {31'b0, full_c},  32'd0);
      chk("mr_ovf",   {31'b0, ovf_c},   32'd0);
      tick(1);
      rst_c = 1'b1;
      tick(1);
      write_word(2, 9'h05A);
      capture(2, bits, blen);
      chk("mr_frame",    {16'b0, bits}, 32'h0000_02B4);
      chk("mr_busy_len", blen, 32'd100);
      chk("mr_empty2",   {31'b0, empty_c}, 32'd1);

`ifdef UART_TX_FIFO_BREAK_EN
      // Break requested mid-frame: frame completes, line held low, then queued word.
      write_word(0, 9'h011);
      tick(19);
      brk_a = 1'b1;
      write_word(0, 9'h022);
      tick(130);
      chk("brk_tx_low", {31'b0, tx_a},   32'd0);
      chk("brk_busy",   {31'b0, busy_a}, 32'd1);
      chk("brk_level",  {27'b0, lvl_a},  32'd1);
      brk_a = 1'b0;
      tick(1);
      chk("brk_release_tx", {31'b0, tx_a}, 32'd1);
      capture(0, bits, blen);
      chk("brk_frame", {16'b0, bits}, 32'h0000_0244);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
